voice_assign: RTL and testbench

Voice allocator for the synth engine: accepts decoded MIDI key events and maps each to one of VOICES voice slots, tracking per-voice key and velocity and an age order for voice stealing. It sits directly upstream of the oscillator-frame synchroniser and drives its note_on / cur_key_adr / cur_key_val / cur_vel_on / keys_on inputs. Each update is held stable long enough for the synchroniser to sample it in a sample frame.

---
 rtl/voice_assign.sv | 158 +++++++++++++++
 tb/tb_voice_assign.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_assign.sv
// voice_assign: maps decoded MIDI key events onto VOICES voice slots.
// Each event is handled as a handshake, then a one-voice-per-cycle scan,
// then a commit. An applied update is frozen on the outputs for HOLD_CYC
// cycles so the downstream frame synchroniser can sample it.
// Voice age is kept as a rank permutation (0 = newest) and is used to pick
// a voice to steal when every slot is sounding.
module voice_assign #(
    parameter int VOICES   = 8,
    parameter int V_WIDTH  = 3,
    parameter int HOLD_CYC = 64
) (
    input  logic               OSC_CLK,
    input  logic               reset_reg_N,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_key_on,
    input  logic [7:0]         ev_key,
    input  logic [7:0]         ev_vel,
    output logic               note_on,
    output logic [V_WIDTH-1:0] cur_key_adr,
    output logic [7:0]         cur_key_val,
    output logic [7:0]         cur_vel_on,
    output logic [VOICES-1:0]  keys_on
);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, HOLD} state_t;

    localparam logic [V_WIDTH-1:0] LAST_IDX  = V_WIDTH'(VOICES - 1);
    localparam logic [15:0]        HOLD_LOAD = 16'(HOLD_CYC - 1);

    state_t state, state_next;

    logic [V_WIDTH-1:0] scan_idx;
    logic [15:0]        hold_cnt;
    logic               lat_on;
    logic [7:0]         lat_key;
    logic [7:0]         lat_vel;

    logic [7:0]         voice_key  [VOICES];
    logic [V_WIDTH-1:0] voice_rank [VOICES];

    logic               match_found;
    logic               free_found;
    logic [V_WIDTH-1:0] match_idx;
    logic [V_WIDTH-1:0] free_idx;
    logic [V_WIDTH-1:0] oldest_idx;
    logic [V_WIDTH-1:0] target;
    logic [V_WIDTH-1:0] target_rank;

    // State register for the event sequencer.
    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) state <= IDLE;
        else              state <= state_next;
    end

    // Next-state selection; a key-off that matched nothing skips HOLD.
    always_comb begin
        state_next = state;
        ev_ready   = (state == IDLE);
        case (state)
            IDLE:    if (ev_valid) state_next = SCAN;
            SCAN:    if (scan_idx == LAST_IDX) state_next = COMMIT;
            COMMIT:  state_next = (lat_on || match_found) ? HOLD : IDLE;
            HOLD:    if (hold_cnt == 16'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Key-on target priority: retrigger a matching voice, else a free one, else steal the oldest.
    always_comb begin
        target = oldest_idx;
        if (match_found)     target = match_idx;
        else if (free_found) target = free_idx;
        target_rank = voice_rank[target];
    end

    // Event latch, voice scan, commit of voice state/outputs and hold countdown.
    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            scan_idx    <= '0;
            hold_cnt    <= '0;
            lat_on      <= 1'b0;
            lat_key     <= '0;
            lat_vel     <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            oldest_idx  <= '0;
            note_on     <= 1'b0;
            cur_key_adr <= '0;
            cur_key_val <= '0;
            cur_vel_on  <= '0;
            keys_on     <= '0;
            for (int i = 0; i < VOICES; i++) begin
                voice_key[i]  <= '0;
                voice_rank[i] <= V_WIDTH'(VOICES - 1 - i);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ev_valid) begin
                        lat_key     <= ev_key & 8'h7F;
                        lat_vel     <= ev_vel;
                        lat_on      <= ev_key_on && (ev_vel != 8'd0);
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        match_idx   <= '0;
                        free_idx    <= '0;
                        oldest_idx  <= '0;
                    end
                end
                SCAN: begin
                    if (keys_on[scan_idx] && (voice_key[scan_idx] == lat_key) && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!keys_on[scan_idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    if (voice_rank[scan_idx] == LAST_IDX) oldest_idx <= scan_idx;
                    scan_idx <= scan_idx + 1'b1;
                end
                COMMIT: begin
                    if (lat_on) begin
                        voice_key[target] <= lat_key;
                        keys_on[target]   <= 1'b1;
                        for (int i = 0; i < VOICES; i++) begin
                            if (V_WIDTH'(i) == target)
                                voice_rank[i] <= '0;
                            else if (voice_rank[i] < target_rank)
                                voice_rank[i] <= voice_rank[i] + 1'b1;
                        end
                        cur_key_adr <= target;
                        cur_key_val <= lat_key;
                        cur_vel_on  <= lat_vel;
                        note_on     <= 1'b1;
                        hold_cnt    <= HOLD_LOAD;
                    end else if (match_found) begin
                        keys_on[match_idx] <= 1'b0;
                        cur_key_adr        <= match_idx;
                        cur_key_val        <= lat_key;
                        note_on            <= 1'b0;
                        hold_cnt           <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == 16'd0) note_on  <= 1'b0;
                    else                   hold_cnt <= hold_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_assign.sv
// Bench for voice_assign: directed key events against a queue-based voice
// allocation model, with every output compared on each falling clock edge
// and a set of hand-computed literal expectations between events.
module tb_voice_assign;

    localparam int VOICES   = 8;
    localparam int V_WIDTH  = 3;
    localparam int HOLD_CYC = 64;

    logic               OSC_CLK;
    logic               reset_reg_N;
    logic               ev_valid;
    logic               ev_ready;
    logic               ev_key_on;
    logic [7:0]         ev_key;
    logic [7:0]         ev_vel;
    logic               note_on;
    logic [V_WIDTH-1:0] cur_key_adr;
    logic [7:0]         cur_key_val;
    logic [7:0]         cur_vel_on;
    logic [VOICES-1:0]  keys_on;

    int checks = 0;
    int errors = 0;

    // Model state: per-voice key and sounding flag, age queue newest-first.
    int m_key [VOICES];
    bit m_act [VOICES];
    int age_q [$];
    int exp_adr, exp_key, exp_vel;
    bit exp_note, exp_ready;

    voice_assign #(
        .VOICES  (VOICES),
        .V_WIDTH (V_WIDTH),
        .HOLD_CYC(HOLD_CYC)
    ) dut (
        .OSC_CLK    (OSC_CLK),
        .reset_reg_N(reset_reg_N),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_key_on  (ev_key_on),
        .ev_key     (ev_key),
        .ev_vel     (ev_vel),
        .note_on    (note_on),
        .cur_key_adr(cur_key_adr),
        .cur_key_val(cur_key_val),
        .cur_vel_on (cur_vel_on),
        .keys_on    (keys_on)
    );

    // 10 ns engine clock.
    initial OSC_CLK = 1'b0;
    always #5 OSC_CLK = ~OSC_CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < VOICES; i++) begin
            m_key[i] = 0;
            m_act[i] = 1'b0;
        end
        age_q.delete();
        for (int i = VOICES - 1; i >= 0; i--) age_q.push_back(i);
        exp_adr   = 0;
        exp_key   = 0;
        exp_vel   = 0;
        exp_note  = 1'b0;
        exp_ready = 1'b1;
    endfunction

    function automatic int keys_mask();
        int m = 0;
        for (int i = 0; i < VOICES; i++) if (m_act[i]) m |= (1 << i);
        return m;
    endfunction

    // Applies one event to the model; returns 1 when it changes anything.
    function automatic bit model_commit(input bit on, input int key, input int vel);
        int match_v = -1;
        int free_v  = -1;
        int tgt;
        for (int i = 0; i < VOICES; i++) begin
            if (m_act[i] && m_key[i] == key && match_v < 0) match_v = i;
            if (!m_act[i] && free_v < 0) free_v = i;
        end
        if (on) begin
            if (match_v >= 0)     tgt = match_v;
            else if (free_v >= 0) tgt = free_v;
            else                  tgt = age_q[age_q.size() - 1];
            m_key[tgt] = key;
            m_act[tgt] = 1'b1;
            for (int j = 0; j < age_q.size(); j++) begin
                if (age_q[j] == tgt) begin
                    age_q.delete(j);
                    break;
                end
            end
            age_q.push_front(tgt);
            exp_adr  = tgt;
            exp_key  = key;
            exp_vel  = vel;
            exp_note = 1'b1;
            return 1'b1;
        end
        if (match_v >= 0) begin
            m_act[match_v] = 1'b0;
            exp_adr  = match_v;
            exp_key  = key;
            exp_note = 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Continuous comparison of every output against the model.
    always @(negedge OSC_CLK) begin
        checkOutput("note_on",     32'(note_on),     32'(exp_note));
        checkOutput("ev_ready",    32'(ev_ready),    32'(exp_ready));
        checkOutput("cur_key_adr", 32'(cur_key_adr), exp_adr);
        checkOutput("cur_key_val", 32'(cur_key_val), exp_key);
        checkOutput("cur_vel_on",  32'(cur_vel_on),  exp_vel);
        checkOutput("keys_on",     32'(keys_on),     keys_mask());
    end

    // Handshake one event, advance the model at the commit edge, then wait out
    // the hold (or return after abort_hold hold cycles when abort_hold > 0).
    task automatic applyStimulus(input bit on, input logic [7:0] key, input logic [7:0] vel, input int abort_hold);
        bit applied;
        @(negedge OSC_CLK);
        ev_valid  = 1'b1;
        ev_key_on = on;
        ev_key    = key;
        ev_vel    = vel;
        @(posedge OSC_CLK);
        #1;
        exp_ready = 1'b0;
        ev_valid  = 1'($urandom_range(0, 1));
        ev_key_on = 1'($urandom_range(0, 1));
        ev_key    = 8'($urandom);
        ev_vel    = 8'($urandom);
        repeat (VOICES) @(posedge OSC_CLK);
        @(posedge OSC_CLK);
        #1;
        applied = model_commit(on && (vel != 8'd0), int'(key & 8'h7F), int'(vel));
        if (!applied) begin
            exp_ready = 1'b1;
            ev_valid  = 1'b0;
            return;
        end
        if (abort_hold > 0) begin
            repeat (abort_hold) @(posedge OSC_CLK);
            #1;
            ev_valid = 1'b0;
            return;
        end
        repeat (HOLD_CYC - 1) @(posedge OSC_CLK);
        @(posedge OSC_CLK);
        #1;
        exp_note  = 1'b0;
        exp_ready = 1'b1;
        ev_valid  = 1'b0;
    endtask

    task automatic check_lit(input string tag, input int adr, input int key, input int vel, input int keys);
        checkOutput({tag, "_adr"},  32'(cur_key_adr), adr);
        checkOutput({tag, "_key"},  32'(cur_key_val), key);
        checkOutput({tag, "_vel"},  32'(cur_vel_on),  vel);
        checkOutput({tag, "_keys"}, 32'(keys_on),     keys);
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_note"},  32'(note_on),  0);
        checkOutput({tag, "_ready"}, 32'(ev_ready), 1);
        check_lit(tag, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge OSC_CLK);
        #2;
        reset_reg_N = 1'b0;
        model_reset();
        #1;
        check_reset_state("rst");
        @(negedge OSC_CLK);
        #2;
        reset_reg_N = 1'b1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ev_valid    = 1'b0;
        ev_key_on   = 1'b0;
        ev_key      = '0;
        ev_vel      = '0;
        reset_reg_N = 1'b0;
        model_reset();
        #1;
        check_reset_state("por");
        repeat (2) @(negedge OSC_CLK);
        #2;
        reset_reg_N = 1'b1;

        $display("[TB] key-on 60 vel 100 into empty engine");
        applyStimulus(1'b1, 8'd60, 8'd100, 0);
        check_lit("first_on", 0, 60, 100, 8'h01);

        $display("[TB] key-off 60");
        applyStimulus(1'b0, 8'd60, 8'd64, 0);
        check_lit("off60", 0, 60, 100, 8'h00);

        $display("[TB] key-on 60 twice, second retriggers");
        applyStimulus(1'b1, 8'd60, 8'd50, 0);
        applyStimulus(1'b1, 8'd60, 8'd90, 0);
        check_lit("retrig", 0, 60, 90, 8'h01);

        $display("[TB] key-on 60 vel 0 acts as key-off");
        applyStimulus(1'b1, 8'd60, 8'd0, 0);
        check_lit("vel0_off", 0, 60, 90, 8'h00);

        $display("[TB] key-off 99 with no match");
        applyStimulus(1'b0, 8'd99, 8'd10, 0);
        check_lit("ign_off", 0, 60, 90, 8'h00);
        checkOutput("ign_off_ready", 32'(ev_ready), 1);

        $display("[TB] fill all voices then steal");
        do_reset();
        applyStimulus(1'b1, 8'hBC, 8'd10, 0);
        check_lit("bit7_key", 0, 60, 10, 8'h01);
        for (int k = 61; k <= 67; k++) applyStimulus(1'b1, 8'(k), 8'(k - 50), 0);
        check_lit("full", 7, 67, 17, 8'hFF);
        applyStimulus(1'b1, 8'd70, 8'd5, 0);
        check_lit("steal0", 0, 70, 5, 8'hFF);
        applyStimulus(1'b1, 8'd71, 8'd6, 0);
        check_lit("steal1", 1, 71, 6, 8'hFF);

        $display("[TB] release one voice then reuse it");
        applyStimulus(1'b0, 8'd65, 8'd0, 0);
        check_lit("off65", 5, 65, 6, 8'hDF);
        applyStimulus(1'b1, 8'd80, 8'd9, 0);
        check_lit("reuse5", 5, 80, 9, 8'hFF);

        $display("[TB] reset in the middle of a hold");
        applyStimulus(1'b1, 8'd33, 8'd7, 10);
        checkOutput("midhold_note", 32'(note_on), 1);
        #1;
        reset_reg_N = 1'b0;
        model_reset();
        #1;
        check_reset_state("midhold");
        @(negedge OSC_CLK);
        #2;
        reset_reg_N = 1'b1;
        applyStimulus(1'b1, 8'd40, 8'd20, 0);
        check_lit("after_rst", 0, 40, 20, 8'h01);

        repeat (2) @(negedge OSC_CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
